// File: rtl/coord_scaler.sv
// Three-stage coordinate zoom: capture sign/magnitude, multiply by an unsigned
// fixed-point zoom, then range-check and restore sign with zero-or-clamp overflow.
module coord_scaler #(
    parameter int CW   = 8,
    parameter int ZW   = 8,
    parameter int FRAC = 0,
    parameter int SAT  = 0
) (
    input  logic          ACLK,
    input  logic          ARESETN,
    input  logic          S_VALID,
    output logic          S_READY,
    input  logic [CW-1:0] S_X,
    input  logic [CW-1:0] S_Y,
    input  logic [ZW-1:0] ZOOM,
    output logic          M_VALID,
    input  logic          M_READY,
    output logic [CW-1:0] M_X,
    output logic [CW-1:0] M_Y,
    output logic          M_OVF
);

    localparam int PW = CW + ZW;
    localparam logic [CW-1:0] MAX_POS = CW'((1 << (CW - 1)) - 1);
    localparam logic [CW-1:0] MAX_NEG = ~MAX_POS + CW'(1);

    logic          adv;
    logic          v1_reg;
    logic          v2_reg;
    logic          v3_reg;
    logic [ZW-1:0] zoom_reg;
    logic [CW-1:0] coord_in [2];
    logic [1:0]    ovf_axis;
    logic [CW-1:0] res_axis [2];

    // The whole pipeline moves in lockstep; bubbles travel as valid=0.
    assign adv     = !v3_reg || M_READY;
    assign S_READY = adv;
    assign M_VALID = v3_reg;

    assign coord_in[0] = S_X;
    assign coord_in[1] = S_Y;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            logic          sign1_reg;
            logic          sign2_reg;
            logic [CW-1:0] abs1_reg;
            logic [PW-1:0] mag2_reg;
            logic [PW-1:0] m;
            logic [CW-1:0] val;
            logic [CW-1:0] sat_val;

            always_ff @(posedge ACLK or negedge ARESETN) begin
                if (!ARESETN) begin
                    sign1_reg <= 1'b0;
                    abs1_reg  <= '0;
                    sign2_reg <= 1'b0;
                    mag2_reg  <= '0;
                end else if (adv) begin
                    sign1_reg <= coord_in[gi][CW-1];
                    // The most negative input maps to magnitude 2^(CW-1), still fits unsigned CW.
                    abs1_reg  <= coord_in[gi][CW-1] ? (~coord_in[gi] + CW'(1)) : coord_in[gi];
                    sign2_reg <= sign1_reg;
                    mag2_reg  <= PW'(abs1_reg) * PW'(zoom_reg);
                end
            end

            assign m            = mag2_reg >> FRAC;
            assign ovf_axis[gi] = (m > PW'(MAX_POS));
            assign val          = sign2_reg ? (~m[CW-1:0] + CW'(1)) : m[CW-1:0];
            assign sat_val      = sign2_reg ? MAX_NEG : MAX_POS;

            // Zero mode blanks both axes; clamp mode only touches the axis that overflowed.
            assign res_axis[gi] = (ovf_axis == 2'b00) ? val :
                                  (SAT == 0)          ? '0  :
                                  ovf_axis[gi]        ? sat_val : val;
        end
    endgenerate

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            v1_reg   <= 1'b0;
            v2_reg   <= 1'b0;
            v3_reg   <= 1'b0;
            zoom_reg <= '0;
            M_X      <= '0;
            M_Y      <= '0;
            M_OVF    <= 1'b0;
        end else if (adv) begin
            v1_reg   <= S_VALID;
            v2_reg   <= v1_reg;
            v3_reg   <= v2_reg;
            zoom_reg <= ZOOM;
            M_X      <= res_axis[0];
            M_Y      <= res_axis[1];
            M_OVF    <= |ovf_axis;
        end
    end

endmodule

// File: tb/tb_coord_scaler.sv
// Bench for coord_scaler: three instances (default, clamp mode, FRAC=4) share
// stimulus and are checked against an arithmetic reference model.
module tb_coord_scaler;

    localparam int N = 3;

    logic              ACLK;
    logic              ARESETN;
    logic              S_VALID;
    logic signed [7:0] S_X;
    logic signed [7:0] S_Y;
    logic [7:0]        ZOOM;
    logic              M_READY;

    logic              s_ready [N];
    logic              m_valid [N];
    logic signed [7:0] m_x     [N];
    logic signed [7:0] m_y     [N];
    logic              m_ovf   [N];

    int frac_p [N] = '{0, 0, 4};
    int sat_p  [N] = '{0, 1, 0};

    int total = 0;
    int bad   = 0;
    logic [23:0] sb_q [$];

    coord_scaler #(.CW(8), .ZW(8), .FRAC(0), .SAT(0)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .S_VALID(S_VALID), .S_READY(s_ready[0]),
        .S_X(S_X), .S_Y(S_Y), .ZOOM(ZOOM), .M_VALID(m_valid[0]), .M_READY(M_READY),
        .M_X(m_x[0]), .M_Y(m_y[0]), .M_OVF(m_ovf[0]));

    coord_scaler #(.CW(8), .ZW(8), .FRAC(0), .SAT(1)) dut_sat (
        .ACLK(ACLK), .ARESETN(ARESETN), .S_VALID(S_VALID), .S_READY(s_ready[1]),
        .S_X(S_X), .S_Y(S_Y), .ZOOM(ZOOM), .M_VALID(m_valid[1]), .M_READY(M_READY),
        .M_X(m_x[1]), .M_Y(m_y[1]), .M_OVF(m_ovf[1]));

    coord_scaler #(.CW(8), .ZW(8), .FRAC(4), .SAT(0)) dut_frac (
        .ACLK(ACLK), .ARESETN(ARESETN), .S_VALID(S_VALID), .S_READY(s_ready[2]),
        .S_X(S_X), .S_Y(S_Y), .ZOOM(ZOOM), .M_VALID(m_valid[2]), .M_READY(M_READY),
        .M_X(m_x[2]), .M_Y(m_y[2]), .M_OVF(m_ovf[2]));

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Reference: scale magnitudes with plain integer arithmetic, then apply the overflow rules.
    function automatic logic [16:0] ref_out(int x, int y, int z, int frac, int sat);
        int   mx, my, rx, ry;
        logic ovx, ovy, ov;
        mx  = ((x < 0) ? -x : x) * z / (1 << frac);
        my  = ((y < 0) ? -y : y) * z / (1 << frac);
        ovx = (mx > 127);
        ovy = (my > 127);
        ov  = ovx | ovy;
        rx  = (x < 0) ? -mx : mx;
        ry  = (y < 0) ? -my : my;
        if (ov) begin
            if (sat == 0) begin
                rx = 0;
                ry = 0;
            end else begin
                if (ovx) rx = (x < 0) ? -127 : 127;
                if (ovy) ry = (y < 0) ? -127 : 127;
            end
        end
        return {ov, rx[7:0], ry[7:0]};
    endfunction

    function automatic logic [16:0] ref_entry(logic [23:0] ent, int k);
        return ref_out(int'($signed(ent[23:16])), int'($signed(ent[15:8])),
                       int'(ent[7:0]), frac_p[k], sat_p[k]);
    endfunction

    task automatic rand_sample();
        int sel;
        sel = int'($urandom_range(0, 7));
        S_X  = (sel == 0) ? -8'sd128 : (sel == 1) ? 8'sd127 : 8'($urandom);
        S_Y  = (sel == 2) ? -8'sd127 : (sel == 3) ? 8'sd0 : 8'($urandom);
        ZOOM = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 24));
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        S_VALID = 1'b0;
        S_X = '0; S_Y = '0; ZOOM = '0;
        M_READY = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b1;
        #1;
        for (int k = 0; k < N; k++) begin
            total++;
            if (m_valid[k] !== 1'b0 || m_ovf[k] !== 1'b0 || m_x[k] !== 8'sd0 ||
                m_y[k] !== 8'sd0 || s_ready[k] !== 1'b1) begin
                bad++;
                $display("FAIL reset_state inst%0d: got valid=%b ovf=%b x=%0d y=%0d ready=%b, want 0 0 0 0 1",
                         k, m_valid[k], m_ovf[k], m_x[k], m_y[k], s_ready[k]);
            end
        end
    endtask

    task automatic test_directed();
        int vx [4] = '{5, 13, -128, -7};
        int vy [4] = '{-3, 2, 0, 9};
        int vz [4] = '{10, 10, 1, 24};
        logic [16:0] exp;
        for (int v = 0; v < 4; v++) begin
            @(negedge ACLK);
            M_READY = 1'b1;
            S_VALID = 1'b1;
            S_X = 8'(vx[v]); S_Y = 8'(vy[v]); ZOOM = 8'(vz[v]);
            #1;
            total++;
            if (s_ready[0] !== 1'b1) begin
                bad++;
                $display("FAIL directed_ready v%0d: got %b want 1", v, s_ready[0]);
            end
            // The accept edge counts as the first of three; output shows after the third.
            for (int e = 1; e <= 4; e++) begin
                @(negedge ACLK);
                S_VALID = 1'b0;
                #1;
                for (int k = 0; k < N; k++) begin
                    exp = ref_out(vx[v], vy[v], vz[v], frac_p[k], sat_p[k]);
                    total++;
                    if (e != 3) begin
                        if (m_valid[k] !== 1'b0) begin
                            bad++;
                            $display("FAIL directed_latency v%0d e%0d inst%0d: got valid=%b want 0", v, e, k, m_valid[k]);
                        end
                    end else if (m_valid[k] !== 1'b1 || m_x[k] !== exp[15:8] ||
                                 m_y[k] !== exp[7:0] || m_ovf[k] !== exp[16]) begin
                        bad++;
                        $display("FAIL directed_value v%0d inst%0d: got valid=%b x=%0d y=%0d ovf=%b want 1 %0d %0d %b",
                                 v, k, m_valid[k], m_x[k], m_y[k], m_ovf[k],
                                 $signed(exp[15:8]), $signed(exp[7:0]), exp[16]);
                    end
                end
                if (v == 0 && e == 3) begin
                    total++;
                    if (m_x[0] !== 8'sd50 || m_y[0] !== -8'sd30) begin
                        bad++;
                        $display("FAIL directed_literal: got x=%0d y=%0d want 50 -30", m_x[0], m_y[0]);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] exp;
        logic [23:0] ent;
        for (int c = 0; c < 66; c++) begin
            @(negedge ACLK);
            M_READY = 1'b1;
            S_VALID = (c < 60) && ($urandom_range(0, 3) != 0);
            rand_sample();
            #1;
            total++;
            if (s_ready[0] !== 1'b1) begin
                bad++;
                $display("FAIL b2b_ready c%0d: got %b want 1", c, s_ready[0]);
            end
            if (m_valid[0] === 1'b1) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra c%0d: got unexpected output want none", c);
                end else begin
                    ent = sb_q.pop_front();
                    for (int k = 0; k < N; k++) begin
                        exp = ref_entry(ent, k);
                        if (m_valid[k] !== 1'b1 || m_x[k] !== exp[15:8] ||
                            m_y[k] !== exp[7:0] || m_ovf[k] !== exp[16]) begin
                            bad++;
                            $display("FAIL b2b_value c%0d inst%0d: got x=%0d y=%0d ovf=%b want %0d %0d %b",
                                     c, k, m_x[k], m_y[k], m_ovf[k],
                                     $signed(exp[15:8]), $signed(exp[7:0]), exp[16]);
                        end
                    end
                end
            end
            if (S_VALID && s_ready[0]) sb_q.push_back({S_X, S_Y, ZOOM});
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_drain: got %0d left want 0", sb_q.size());
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int got  = 0;
        logic need_new = 1'b1;
        logic [16:0] exp;
        logic [23:0] ent;
        for (int c = 0; c < 8; c++) begin
            @(negedge ACLK);
            M_READY = 1'b0;
            S_VALID = (sent < 6);
            if (need_new) rand_sample();
            #1;
            if (m_valid[0] === 1'b1) begin
                total++;
                if (s_ready[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_ready_drop c%0d: got %b want 0", c, s_ready[0]);
                end
            end
            need_new = S_VALID && s_ready[0];
            if (need_new) begin
                sb_q.push_back({S_X, S_Y, ZOOM});
                sent++;
            end
        end
        total++;
        if (sent != 3) begin
            bad++;
            $display("FAIL bp_inflight: got %0d accepted want 3", sent);
        end
        for (int c = 0; c < 200 && got < 6; c++) begin
            @(negedge ACLK);
            M_READY = ($urandom_range(0, 1) == 1);
            S_VALID = (sent < 6);
            if (need_new) rand_sample();
            #1;
            if (m_valid[0] === 1'b1) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL bp_extra c%0d: got unexpected output want none", c);
                end else begin
                    // Stalled or accepted, the held output must match the oldest outstanding sample.
                    ent = M_READY ? sb_q.pop_front() : sb_q[0];
                    for (int k = 0; k < N; k++) begin
                        exp = ref_entry(ent, k);
                        if (m_valid[k] !== 1'b1 || m_x[k] !== exp[15:8] ||
                            m_y[k] !== exp[7:0] || m_ovf[k] !== exp[16]) begin
                            bad++;
                            $display("FAIL bp_value c%0d inst%0d rdy=%b: got x=%0d y=%0d ovf=%b want %0d %0d %b",
                                     c, k, M_READY, m_x[k], m_y[k], m_ovf[k],
                                     $signed(exp[15:8]), $signed(exp[7:0]), exp[16]);
                        end
                    end
                    if (M_READY) got++;
                end
            end
            need_new = S_VALID && s_ready[0];
            if (need_new) begin
                sb_q.push_back({S_X, S_Y, ZOOM});
                sent++;
            end
        end
        total++;
        if (got != 6 || sb_q.size() != 0) begin
            bad++;
            $display("FAIL bp_complete: got %0d out %0d pending want 6 out 0 pending", got, sb_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        int sx [3] = '{13, 40, -9};
        int sy [3] = '{2, -1, 30};
        logic [16:0] exp;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            M_READY = 1'b0;
            S_VALID = 1'b1;
            S_X = 8'(sx[i]); S_Y = 8'(sy[i]); ZOOM = 8'd10;
        end
        @(negedge ACLK);
        S_VALID = 1'b0;
        #1;
        total++;
        if (m_valid[0] !== 1'b1 || m_ovf[0] !== 1'b1 || m_x[1] !== 8'sd127) begin
            bad++;
            $display("FAIL rst_pre: got valid=%b ovf=%b satx=%0d want 1 1 127", m_valid[0], m_ovf[0], m_x[1]);
        end
        ARESETN = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            total++;
            if (m_valid[k] !== 1'b0 || m_ovf[k] !== 1'b0 || m_x[k] !== 8'sd0 || m_y[k] !== 8'sd0) begin
                bad++;
                $display("FAIL rst_async inst%0d: got valid=%b ovf=%b x=%0d y=%0d want 0 0 0 0",
                         k, m_valid[k], m_ovf[k], m_x[k], m_y[k]);
            end
        end
        #1;
        ARESETN = 1'b1;
        #1;
        total++;
        if (s_ready[0] !== 1'b1) begin
            bad++;
            $display("FAIL rst_ready: got %b want 1", s_ready[0]);
        end
        M_READY = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge ACLK);
            #1;
            total++;
            if (m_valid[0] !== 1'b0) begin
                bad++;
                $display("FAIL rst_stale c%0d: got valid=%b want 0", c, m_valid[0]);
            end
        end
        @(negedge ACLK);
        S_VALID = 1'b1;
        S_X = -8'sd7; S_Y = 8'sd9; ZOOM = 8'h18;
        for (int e = 1; e <= 3; e++) begin
            @(negedge ACLK);
            S_VALID = 1'b0;
            #1;
            for (int k = 0; k < N; k++) begin
                exp = ref_out(-7, 9, 24, frac_p[k], sat_p[k]);
                total++;
                if ((e < 3 && m_valid[k] !== 1'b0) ||
                    (e == 3 && (m_valid[k] !== 1'b1 || m_x[k] !== exp[15:8] ||
                                m_y[k] !== exp[7:0] || m_ovf[k] !== exp[16]))) begin
                    bad++;
                    $display("FAIL rst_after e%0d inst%0d: got valid=%b x=%0d y=%0d ovf=%b want valid=%b %0d %0d %b",
                             e, k, m_valid[k], m_x[k], m_y[k], m_ovf[k], (e == 3),
                             $signed(exp[15:8]), $signed(exp[7:0]), exp[16]);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
